// File: rtl/des_fp_serializer.sv
// DES output stage: applies IP^-1 to {R16,L16}, registers the ciphertext and streams it MSB-first in SER_W-bit beats.
// Beat 0 appears the cycle after capture; out_ready low freezes the beat and holds in_ready low until the last beat leaves.
module des_fp_serializer #(
    parameter int SER_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      l16,
    input  logic [31:0]      r16,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SER_W-1:0] out_data,
    output logic             out_last,
    output logic [63:0]      block_out,
    output logic             busy
);
    localparam int BEATS = 64 / SER_W;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [63:0]   shift_q, shift_d;
    logic [63:0]   block_q, block_d;
    logic [63:0]   pre, cph;
    logic          last_beat, capture, accept;

    // DES bit n (1 = MSB) lives at vector index 64-n.
    assign pre = {r16, l16};

    for (genvar gi = 1; gi <= 64; gi++) begin : g_fp
        localparam int K   = (gi - 1) % 8;
        localparam int R   = (gi - 1) / 8;
        localparam int SRC = ((K % 2) == 0) ? (40 + 4 * K - R) : (4 + 4 * K - R);
        assign cph[64-gi] = pre[64-SRC];
    end

    assign last_beat = (cnt_q == LAST_CNT);

    // in_ready reaches back through out_ready so a new block can land on the last beat without a bubble.
    always_comb begin
        out_valid = 1'b0;
        out_last  = 1'b0;
        busy      = 1'b0;
        in_ready  = 1'b0;
        out_data  = '0;
        if (rst_n) begin
            out_valid = (state_q == SEND);
            busy      = (state_q == SEND);
            out_last  = (state_q == SEND) && last_beat;
            in_ready  = (state_q == IDLE) || (out_ready && last_beat);
            out_data  = shift_q[63 -: SER_W];
        end
    end

    assign capture   = in_valid && in_ready;
    assign accept    = out_valid && out_ready;
    assign block_out = block_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        block_d = block_q;
        if (accept && !last_beat) begin
            shift_d = shift_q << SER_W;
            cnt_d   = cnt_q + 1'b1;
        end
        if (accept && last_beat) begin
            state_d = IDLE;
        end
        if (capture) begin
            state_d = SEND;
            cnt_d   = '0;
            shift_d = cph;
            block_d = cph;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            block_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            block_q <= block_d;
        end
    end
endmodule

// File: tb/tb_des_fp_serializer.sv
// Directed bench for des_fp_serializer at beat widths 8, 64, 16 and 32.
module tb_des_fp_serializer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    localparam logic [31:0] FIPS_L = 32'h43423234;
    localparam logic [31:0] FIPS_R = 32'h0A4CD995;
    localparam logic [63:0] FIPS_C = 64'h85E813540F0AB405;

    // a: SER_W=8, b: SER_W=64, c: SER_W=16, d: SER_W=32
    logic        a_iv, a_ir, a_ov, a_or, a_ol, a_busy;
    logic [31:0] a_l, a_r;
    logic [7:0]  a_od;
    logic [63:0] a_blk;
    logic        b_iv, b_ir, b_ov, b_or, b_ol, b_busy;
    logic [31:0] b_l, b_r;
    logic [63:0] b_od, b_blk;
    logic        c_iv, c_ir, c_ov, c_or, c_ol, c_busy;
    logic [31:0] c_l, c_r;
    logic [15:0] c_od;
    logic [63:0] c_blk;
    logic        d_iv, d_ir, d_ov, d_or, d_ol, d_busy;
    logic [31:0] d_l, d_r;
    logic [31:0] d_od;
    logic [63:0] d_blk;

    des_fp_serializer #(.SER_W(8)) u_a (.clk(clk), .rst_n(rst_n), .in_valid(a_iv), .in_ready(a_ir),
        .l16(a_l), .r16(a_r), .out_valid(a_ov), .out_ready(a_or), .out_data(a_od), .out_last(a_ol),
        .block_out(a_blk), .busy(a_busy));
    des_fp_serializer #(.SER_W(64)) u_b (.clk(clk), .rst_n(rst_n), .in_valid(b_iv), .in_ready(b_ir),
        .l16(b_l), .r16(b_r), .out_valid(b_ov), .out_ready(b_or), .out_data(b_od), .out_last(b_ol),
        .block_out(b_blk), .busy(b_busy));
    des_fp_serializer #(.SER_W(16)) u_c (.clk(clk), .rst_n(rst_n), .in_valid(c_iv), .in_ready(c_ir),
        .l16(c_l), .r16(c_r), .out_valid(c_ov), .out_ready(c_or), .out_data(c_od), .out_last(c_ol),
        .block_out(c_blk), .busy(c_busy));
    des_fp_serializer #(.SER_W(32)) u_d (.clk(clk), .rst_n(rst_n), .in_valid(d_iv), .in_ready(d_ir),
        .l16(d_l), .r16(d_r), .out_valid(d_ov), .out_ready(d_or), .out_data(d_od), .out_last(d_ol),
        .block_out(d_blk), .busy(d_busy));

    typedef struct {
        logic [31:0] l;
        logic [31:0] r;
        logic [63:0] c;
    } vec_t;
    vec_t vt[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] blk;
        vt[0] = '{FIPS_L, FIPS_R, FIPS_C};
        vt[1] = '{32'h00000000, 32'h80000000, 64'h0000000000000040};
        vt[2] = '{32'h80000000, 32'h00000000, 64'h0000000000000080};
        vt[3] = '{32'h00000000, 32'h00000001, 64'h0100000000000000};
        vt[4] = '{32'h00000001, 32'h00000000, 64'h0200000000000000};
        vt[5] = '{32'hFFFFFFFF, 32'h00000000, 64'hAAAAAAAAAAAAAAAA};
        vt[6] = '{32'h00000000, 32'hFFFFFFFF, 64'h5555555555555555};

        {a_iv, a_or, b_iv, b_or, c_iv, c_or, d_iv, d_or} = '0;
        {a_l, a_r, b_l, b_r, c_l, c_r, d_l, d_r} = '0;

        // Reset held 3 cycles with in_valid high: nothing may be captured.
        a_iv = 1'b1; a_l = FIPS_L; a_r = FIPS_R; a_or = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_in_ready", 64'(a_ir), 64'd0);
            chk("rst_out_valid", 64'(a_ov), 64'd0);
            chk("rst_busy", 64'(a_busy), 64'd0);
            chk("rst_out_last", 64'(a_ol), 64'd0);
            step();
            chk("rst_block_out", a_blk, 64'd0);
            chk("rst_out_data", 64'(a_od), 64'd0);
        end
        a_iv = 1'b0;
        rst_n = 1'b1;
        step();
        chk("post_rst_in_ready", 64'(a_ir), 64'd1);
        chk("post_rst_out_valid", 64'(a_ov), 64'd0);
        chk("post_rst_block_out", a_blk, 64'd0);

        // FIPS example, 8-bit beats.
        a_iv = 1'b1; a_or = 1'b1;
        step();
        a_iv = 1'b0;
        chk("fips8_block_out", a_blk, FIPS_C);
        blk = FIPS_C;
        for (int b = 0; b < 8; b++) begin
            chk("fips8_out_valid", 64'(a_ov), 64'd1);
            chk("fips8_beat", 64'(a_od), 64'(blk[63-8*b -: 8]));
            chk("fips8_out_last", 64'(a_ol), 64'(b == 7));
            chk("fips8_in_ready", 64'(a_ir), 64'(b == 7));
            chk("fips8_busy", 64'(a_busy), 64'd1);
            step();
        end
        chk("fips8_idle_valid", 64'(a_ov), 64'd0);

        // Permutation table, one beat per block.
        b_or = 1'b0;
        for (int v = 0; v < 7; v++) begin
            chk("tbl_in_ready", 64'(b_ir), 64'd1);
            b_l = vt[v].l; b_r = vt[v].r; b_iv = 1'b1;
            step();
            b_iv = 1'b0;
            chk("tbl_out_valid", 64'(b_ov), 64'd1);
            chk("tbl_out_data", b_od, vt[v].c);
            chk("tbl_block_out", b_blk, vt[v].c);
            chk("tbl_out_last", 64'(b_ol), 64'd1);
            b_or = 1'b1;
            #1;
            chk("tbl_in_ready_last", 64'(b_ir), 64'd1);
            step();
            b_or = 1'b0;
            chk("tbl_drained", 64'(b_ov), 64'd0);
        end

        // Backpressure, 16-bit beats: out_ready pattern 1,0,0,1,0,0,...
        c_l = FIPS_L; c_r = FIPS_R; c_iv = 1'b1; c_or = 1'b0;
        step();
        c_iv = 1'b0;
        for (int b = 0; b < 4; b++) begin
            if (b != 0) begin
                for (int s = 0; s < 2; s++) begin
                    c_or = 1'b0;
                    #1;
                    chk("bp_stall_valid", 64'(c_ov), 64'd1);
                    chk("bp_stall_beat", 64'(c_od), 64'(blk[63-16*b -: 16]));
                    chk("bp_stall_last", 64'(c_ol), 64'(b == 3));
                    chk("bp_stall_in_ready", 64'(c_ir), 64'd0);
                    step();
                end
            end
            c_or = 1'b1;
            #1;
            chk("bp_beat", 64'(c_od), 64'(blk[63-16*b -: 16]));
            chk("bp_in_ready", 64'(c_ir), 64'(b == 3));
            step();
        end
        c_or = 1'b0;
        chk("bp_idle", 64'(c_ov), 64'd0);

        // Back-to-back, 32-bit beats: FIPS then all-zero.
        d_or = 1'b1; d_l = FIPS_L; d_r = FIPS_R; d_iv = 1'b1;
        step();
        d_l = '0; d_r = '0;
        chk("b2b_beat0", 64'(d_od), 64'h85E81354);
        chk("b2b_valid0", 64'(d_ov), 64'd1);
        chk("b2b_in_ready0", 64'(d_ir), 64'd0);
        step();
        chk("b2b_beat1", 64'(d_od), 64'h0F0AB405);
        chk("b2b_last1", 64'(d_ol), 64'd1);
        chk("b2b_in_ready1", 64'(d_ir), 64'd1);
        step();
        chk("b2b_valid2", 64'(d_ov), 64'd1);
        chk("b2b_beat2", 64'(d_od), 64'h0);
        chk("b2b_last2", 64'(d_ol), 64'd0);
        chk("b2b_in_ready2", 64'(d_ir), 64'd0);
        chk("b2b_block2", d_blk, 64'h0);
        step();
        d_iv = 1'b0;
        chk("b2b_valid3", 64'(d_ov), 64'd1);
        chk("b2b_last3", 64'(d_ol), 64'd1);
        chk("b2b_in_ready3", 64'(d_ir), 64'd1);
        step();
        chk("b2b_idle", 64'(d_ov), 64'd0);

        // Reset after beat 2 is accepted, then a fresh block.
        a_l = FIPS_L; a_r = FIPS_R; a_iv = 1'b1; a_or = 1'b1;
        step();
        a_iv = 1'b0;
        step();
        step();
        step();
        chk("mrst_beat3_before", 64'(a_od), 64'h54);
        rst_n = 1'b0;
        #1;
        chk("mrst_valid_during", 64'(a_ov), 64'd0);
        step();
        chk("mrst_block_out", a_blk, 64'd0);
        rst_n = 1'b1;
        #1;
        chk("mrst_valid_after", 64'(a_ov), 64'd0);
        chk("mrst_in_ready", 64'(a_ir), 64'd1);
        a_iv = 1'b1;
        step();
        a_iv = 1'b0;
        chk("mrst_restart_beat", 64'(a_od), 64'h85);
        chk("mrst_restart_block", a_blk, FIPS_C);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
